power_k_shift_pipe: RTL and testbench
=====================================

POWER_K_SHIFT_PIPE -- requirements
Module: power_k_shift_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16: base data width; output width is 2*WIDTH.
REQ-002 SHALL have parameter ROUN_WIDTH, default 0: extra input bits; input width is WIDTH+ROUN_WIDTH.
REQ-003 SHALL have parameter LOG2_WIDTH, default 4: shift-amount width; K ranges 0..2^LOG2_WIDTH-1.
REQ-004 SHALL have port clk  input  1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid  input  1: IN/K/MODE valid this cycle.
REQ-007 SHALL have port in_ready  output  1: block accepts a transaction this cycle.
REQ-008 SHALL have port IN  input  WIDTH+ROUN_WIDTH: operand.
REQ-009 SHALL have port K  input  LOG2_WIDTH: shift amount.
REQ-010 SHALL have port MODE  input  2: 00 SHL unsigned, 01 SHR logical, 10 SHR arithmetic, 11 SHL signed.
REQ-011 SHALL have port out_valid  output  1: OUT_2K/OVF valid.
REQ-012 SHALL have port out_ready  input  1: consumer accepts result.
REQ-013 SHALL have port OUT_2K  output  2*WIDTH: shifted result.
REQ-014 SHALL have port OVF  output  1: nonzero/significant bits lost off the top on a left shift.

Function
REQ-015 SHALL extend IN to 2*WIDTH before shifting: zero-extend for modes 00/01, sign-extend (MSB of IN) for modes 10/11; if WIDTH+ROUN_WIDTH > 2*WIDTH, truncation bits SHALL count toward OVF for left modes.
REQ-016 SHALL compute SHL modes as extended operand multiplied by 2^K, SHR logical as zero-fill right shift by K, SHR arithmetic as sign-fill right shift by K.
REQ-017 SHALL set OVF in mode 00 when any bit of IN<<K above bit 2*WIDTH-1 is 1; in mode 11 when any bit shifted out or the result sign differs from IN sign; OVF SHALL be 0 for right modes.
REQ-018 SHALL be a two-stage pipeline: stage 1 shifts by K[LOG2_WIDTH/2-1:0] (lower half, rounded down), stage 2 by remaining upper K bits; OVF accumulated across stages.
REQ-019 SHALL have latency exactly 2 cycles from accepted input (in_valid&in_ready) to out_valid with out_ready held high; throughput 1 per cycle.
REQ-020 SHALL advance each stage when it is empty or the downstream stage advances; stage 2 advances when out_valid=0 or out_ready=1.
REQ-021 SHALL drive in_ready = !s1_valid | s1_advance (combinational from out_ready allowed, no combinational path from in_valid).
REQ-022 SHALL hold OUT_2K, OVF, out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL with both stages full and out_ready=0 deassert in_ready; SHALL on the cycle out_ready rises accept a new input simultaneously (no bubble).
REQ-024 SHALL treat K=0 as pass-through of the extended operand, OVF=0 unless truncation per REQ-015.
REQ-025 SHALL carry MODE with data through both stages; a new MODE per transaction SHALL NOT affect in-flight results.

Reset
REQ-026 SHALL on rst=1 clear s1_valid, s2_valid, out_valid to 0, OUT_2K to 0, OVF to 0 at the next clock edge.
REQ-027 SHALL drop in-flight transactions when rst asserts mid-operation; in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-028 SHALL place MODE encodings (SHL_U, SHR_L, SHR_A, SHL_S) as constants in a shared package power_k_pkg.
REQ-029 SHALL use one sub-module power_k_stage (registered partial shifter with valid/ready and OVF input/output), instantiated twice.

Verification
REQ-030 SHALL check WIDTH=16: IN=0x0001, K=15, MODE=00 -> OUT_2K=0x00008000, OVF=0, out_valid exactly 2 cycles after acceptance.
REQ-031 SHALL check WIDTH=16: IN=0x8000, K=4, MODE=10 -> OUT_2K=0xFFFFF800; MODE=01 -> 0x00000800.
REQ-032 SHALL check WIDTH=8, ROUN_WIDTH=2, LOG2_WIDTH=3: IN=0x3FF, K=7, MODE=00 -> OUT_2K=0xFF80, OVF=1; K=6 -> 0xFFC0, OVF=0.
REQ-033 SHALL check backpressure: 4 back-to-back inputs, out_ready=0 for 5 cycles -> in_ready low after 2 accepted, outputs held, all 4 results in order with no loss/duplication once out_ready=1.
REQ-034 SHALL check WIDTH=16 MODE=11: IN=0xC000, K=1 -> 0xFFFF8000, OVF=0; IN=0x4000, K=17 unreachable, use K=15 -> 0x20000000, OVF=0.
REQ-035 SHALL check rst asserted with 2 transactions in flight -> out_valid=0 next cycle, no stale result appears after release.

Source files
------------

// File: rtl/power_k_pkg.sv
// Shared mode encodings and helpers for the two-stage power-of-two shift pipeline.
package power_k_pkg;

    typedef enum logic [1:0] {
        SHL_U = 2'b00,
        SHR_L = 2'b01,
        SHR_A = 2'b10,
        SHL_S = 2'b11
    } mode_e;

    // Modes that sign-extend the operand before shifting.
    function automatic logic is_sign_ext(input mode_e mode);
        return (mode == SHR_A) || (mode == SHL_S);
    endfunction

endpackage

// File: rtl/power_k_stage.sv
// One registered partial shifter: shifts by the K bits selected by SHIFT_MASK,
// ORs in upstream overflow, and carries MODE/K forward with valid/ready handshaking.
module power_k_stage
    import power_k_pkg::*;
#(
    parameter int              OW         = 32,
    parameter int              KW         = 4,
    parameter logic [KW-1:0]   SHIFT_MASK = '1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [OW-1:0] i_data,
    input  logic          i_ovf,
    input  mode_e         i_mode,
    input  logic [KW-1:0] i_k,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [OW-1:0] o_data,
    output logic          o_ovf,
    output mode_e         o_mode,
    output logic [KW-1:0] o_k
);
    // Headroom so every bit pushed past the result width is still visible for overflow.
    localparam int EW = OW + (1 << KW);

    logic          w_advance;
    logic [KW-1:0] w_shamt;
    logic [EW-1:0] w_wide;
    logic [OW-1:0] w_res;
    logic          w_ovf;

    logic          r_valid;
    logic [OW-1:0] r_data;
    logic          r_ovf;
    mode_e         r_mode;
    logic [KW-1:0] r_k;

    assign w_shamt   = i_k & SHIFT_MASK;
    assign w_advance = !r_valid || i_ready;
    assign o_ready   = w_advance;

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        w_wide = '0;
        w_res  = '0;
        w_ovf  = 1'b0;
        case (i_mode)
            SHL_U: begin
                w_wide = EW'(i_data) << w_shamt;
                w_res  = w_wide[OW-1:0];
                w_ovf  = |w_wide[EW-1:OW];
            end
            SHL_S: begin
                w_wide = EW'($signed(i_data)) << w_shamt;
                w_res  = w_wide[OW-1:0];
                w_ovf  = (w_wide[EW-1:OW-1] != {(EW-OW+1){i_data[OW-1]}});
            end
            SHR_L:   w_res = i_data >> w_shamt;
            SHR_A:   w_res = OW'($signed(i_data) >>> w_shamt);
            default: w_res = '0;
        endcase
    end

    // NOTE: non-blocking assignments so all stage registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ovf   <= 1'b0;
            r_mode  <= SHL_U;
            r_k     <= '0;
        end else if (w_advance) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= w_res;
                r_ovf  <= i_ovf | w_ovf;
                r_mode <= i_mode;
                r_k    <= i_k;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_ovf   = r_ovf;
    assign o_mode  = r_mode;
    assign o_k     = r_k;

endmodule

// File: rtl/power_k_shift_pipe.sv
// Two-stage shifter by 2^K: stage 1 handles the low half of K, stage 2 the rest,
// with overflow accumulated across stages and elastic valid/ready flow control.
module power_k_shift_pipe
    import power_k_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ROUN_WIDTH = 0,
    parameter int LOG2_WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH+ROUN_WIDTH-1:0] IN,
    input  logic [LOG2_WIDTH-1:0]       K,
    input  logic [1:0]                  MODE,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [2*WIDTH-1:0]          OUT_2K,
    output logic                        OVF
);
    localparam int IW        = WIDTH + ROUN_WIDTH;
    localparam int OW        = 2 * WIDTH;
    localparam int K_LO_BITS = LOG2_WIDTH / 2;
    localparam logic [LOG2_WIDTH-1:0] LO_MASK = LOG2_WIDTH'((1 << K_LO_BITS) - 1);
    localparam logic [LOG2_WIDTH-1:0] HI_MASK = ~LO_MASK;

    mode_e                 w_mode;
    logic [OW-1:0]         w_ext;
    logic                  w_trunc_ovf;
    logic                  w_s1_valid;
    logic                  w_s2_ready;
    logic [OW-1:0]         w_s1_data;
    logic                  w_s1_ovf;
    mode_e                 w_s1_mode;
    logic [LOG2_WIDTH-1:0] w_s1_k;
    mode_e                 w_s2_mode;
    logic [LOG2_WIDTH-1:0] w_s2_k;
    logic                  w_unused_s2;

    assign w_mode = mode_e'(MODE);
    assign w_ext  = is_sign_ext(w_mode) ? OW'($signed(IN)) : OW'(IN);

    // Input bits that do not fit the result width are already lost for left shifts.
    generate
        if (IW > OW) begin : g_trunc
            assign w_trunc_ovf = (w_mode == SHL_U) ? |IN[IW-1:OW] :
                                 (w_mode == SHL_S) ? (IN[IW-1:OW-1] != {(IW-OW+1){IN[IW-1]}}) :
                                 1'b0;
        end else begin : g_no_trunc
            assign w_trunc_ovf = 1'b0;
        end
    endgenerate

    power_k_stage #(
        .OW         (OW),
        .KW         (LOG2_WIDTH),
        .SHIFT_MASK (LO_MASK)
    ) u_stage1 (
        .clk     (clk),
        .rst     (rst),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_ext),
        .i_ovf   (w_trunc_ovf),
        .i_mode  (w_mode),
        .i_k     (K),
        .o_valid (w_s1_valid),
        .i_ready (w_s2_ready),
        .o_data  (w_s1_data),
        .o_ovf   (w_s1_ovf),
        .o_mode  (w_s1_mode),
        .o_k     (w_s1_k)
    );

    power_k_stage #(
        .OW         (OW),
        .KW         (LOG2_WIDTH),
        .SHIFT_MASK (HI_MASK)
    ) u_stage2 (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_s1_valid),
        .o_ready (w_s2_ready),
        .i_data  (w_s1_data),
        .i_ovf   (w_s1_ovf),
        .i_mode  (w_s1_mode),
        .i_k     (w_s1_k),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (OUT_2K),
        .o_ovf   (OVF),
        .o_mode  (w_s2_mode),
        .o_k     (w_s2_k)
    );

    assign w_unused_s2 = ^{w_s2_mode, w_s2_k};

endmodule

// File: tb/tb_power_k_shift_pipe.sv
// Directed bench: default 16-bit instance plus an 8-bit/2-extra-bit/3-bit-K instance.
module tb_power_k_shift_pipe;
    import power_k_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ovf;
    logic [15:0] a_in;
    logic [3:0]  a_k;
    logic [1:0]  a_mode;
    logic [31:0] a_out;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ovf;
    logic [9:0]  b_in;
    logic [2:0]  b_k;
    logic [1:0]  b_mode;
    logic [15:0] b_out;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    power_k_shift_pipe #(.WIDTH(16), .ROUN_WIDTH(0), .LOG2_WIDTH(4)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .IN        (a_in),
        .K         (a_k),
        .MODE      (a_mode),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .OUT_2K    (a_out),
        .OVF       (a_ovf)
    );

    power_k_shift_pipe #(.WIDTH(8), .ROUN_WIDTH(2), .LOG2_WIDTH(3)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .IN        (b_in),
        .K         (b_k),
        .MODE      (b_mode),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .OUT_2K    (b_out),
        .OVF       (b_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Accept one transaction, then confirm it appears exactly two edges later.
    task automatic run_a(input string tag, input logic [15:0] v, input logic [3:0] k,
                         input logic [1:0] mode, input logic [31:0] exp_out, input logic exp_ovf);
        a_out_ready = 1'b1;
        a_in = v; a_k = k; a_mode = mode; a_in_valid = 1'b1;
        #1;
        check({tag, "/in_ready"}, a_in_ready, 1'b1);
        tick();
        a_in_valid = 1'b0;
        check({tag, "/lat1"}, a_out_valid, 1'b0);
        tick();
        check({tag, "/valid"}, a_out_valid, 1'b1);
        check({tag, "/out"}, a_out, exp_out);
        check({tag, "/ovf"}, a_ovf, exp_ovf);
    endtask

    task automatic run_b(input string tag, input logic [9:0] v, input logic [2:0] k,
                         input logic [1:0] mode, input logic [15:0] exp_out, input logic exp_ovf);
        b_out_ready = 1'b1;
        b_in = v; b_k = k; b_mode = mode; b_in_valid = 1'b1;
        #1;
        check({tag, "/in_ready"}, b_in_ready, 1'b1);
        tick();
        b_in_valid = 1'b0;
        check({tag, "/lat1"}, b_out_valid, 1'b0);
        tick();
        check({tag, "/valid"}, b_out_valid, 1'b1);
        check({tag, "/out"}, b_out, exp_out);
        check({tag, "/ovf"}, b_ovf, exp_ovf);
    endtask

    initial begin
        rst = 1'b1;
        a_in_valid = 1'b0; a_in = '0; a_k = '0; a_mode = SHL_U; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in = '0; b_k = '0; b_mode = SHL_U; b_out_ready = 1'b1;
        tick();
        tick();
        check("rst/a_valid", a_out_valid, 1'b0);
        check("rst/a_out", a_out, 32'h0);
        check("rst/a_ovf", a_ovf, 1'b0);
        check("rst/b_valid", b_out_valid, 1'b0);
        check("rst/b_out", b_out, 16'h0);
        rst = 1'b0;
        #1;
        check("rst/a_in_ready", a_in_ready, 1'b1);

        run_a("a_shl15",  16'h0001, 4'd15, SHL_U, 32'h0000_8000, 1'b0);
        run_a("a_sra4",   16'h8000, 4'd4,  SHR_A, 32'hFFFF_F800, 1'b0);
        run_a("a_srl4",   16'h8000, 4'd4,  SHR_L, 32'h0000_0800, 1'b0);
        run_a("a_sls1",   16'hC000, 4'd1,  SHL_S, 32'hFFFF_8000, 1'b0);
        run_a("a_sls15",  16'h4000, 4'd15, SHL_S, 32'h2000_0000, 1'b0);
        run_a("a_k0_sra", 16'h8001, 4'd0,  SHR_A, 32'hFFFF_8001, 1'b0);
        run_a("a_k0_shl", 16'hABCD, 4'd0,  SHL_U, 32'h0000_ABCD, 1'b0);
        run_a("a_shl_max",16'hFFFF, 4'd15, SHL_U, 32'h7FFF_8000, 1'b0);
        run_a("a_sls_neg",16'h8000, 4'd15, SHL_S, 32'hC000_0000, 1'b0);
        run_a("a_srl8",   16'h1234, 4'd8,  SHR_L, 32'h0000_0012, 1'b0);
        run_a("a_sra5",   16'h8421, 4'd5,  SHR_A, 32'hFFFF_FC21, 1'b0);

        run_b("b_shl7",   10'h3FF, 3'd7, SHL_U, 16'hFF80, 1'b1);
        run_b("b_shl6",   10'h3FF, 3'd6, SHL_U, 16'hFFC0, 1'b0);
        run_b("b_sls_m1", 10'h3FF, 3'd7, SHL_S, 16'hFF80, 1'b0);
        run_b("b_sls_ov", 10'h1FF, 3'd7, SHL_S, 16'hFF80, 1'b1);
        run_b("b_sls6",   10'h100, 3'd6, SHL_S, 16'h4000, 1'b0);
        run_b("b_sls7",   10'h100, 3'd7, SHL_S, 16'h8000, 1'b1);
        run_b("b_sra3",   10'h200, 3'd3, SHR_A, 16'hFFC0, 1'b0);
        run_b("b_srl3",   10'h200, 3'd3, SHR_L, 16'h0040, 1'b0);
        run_b("b_k0",     10'h2AB, 3'd0, SHR_L, 16'h02AB, 1'b0);
        run_b("b_srl7",   10'h3FF, 3'd7, SHR_L, 16'h0007, 1'b0);

        // Backpressure: fill both stages, hold, then release with a same-cycle accept.
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in = 16'h0001; a_k = 4'd1; a_mode = SHL_U;
        #1;
        check("bp/rdy0", a_in_ready, 1'b1);
        tick();
        a_in = 16'h0003; a_k = 4'd2; a_mode = SHL_U;
        #1;
        check("bp/rdy1", a_in_ready, 1'b1);
        check("bp/empty", a_out_valid, 1'b0);
        tick();
        a_in = 16'h00F0; a_k = 4'd4; a_mode = SHR_L;
        #1;
        check("bp/full_rdy", a_in_ready, 1'b0);
        check("bp/full_valid", a_out_valid, 1'b1);
        check("bp/full_out", a_out, 32'h2);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp/hold_rdy", a_in_ready, 1'b0);
            check("bp/hold_valid", a_out_valid, 1'b1);
            check("bp/hold_out", a_out, 32'h2);
            check("bp/hold_ovf", a_ovf, 1'b0);
        end
        a_out_ready = 1'b1;
        #1;
        check("bp/no_bubble", a_in_ready, 1'b1);
        tick();
        a_in = 16'h0010; a_k = 4'd8; a_mode = SHL_U;
        #1;
        check("bp/r1_valid", a_out_valid, 1'b1);
        check("bp/r1_out", a_out, 32'hC);
        check("bp/r1_rdy", a_in_ready, 1'b1);
        tick();
        a_in_valid = 1'b0;
        check("bp/r2_out", a_out, 32'hF);
        tick();
        check("bp/r3_out", a_out, 32'h1000);
        tick();
        check("bp/drained", a_out_valid, 1'b0);

        // Reset with two transactions in flight must drop both.
        a_out_ready = 1'b1;
        a_in_valid = 1'b1; a_in = 16'h0005; a_k = 4'd3; a_mode = SHL_U;
        tick();
        a_in = 16'h0007; a_k = 4'd1;
        tick();
        a_in_valid = 1'b0;
        check("mid/pre_valid", a_out_valid, 1'b1);
        check("mid/pre_out", a_out, 32'h28);
        rst = 1'b1;
        tick();
        check("mid/valid", a_out_valid, 1'b0);
        check("mid/out", a_out, 32'h0);
        check("mid/ovf", a_ovf, 1'b0);
        rst = 1'b0;
        #1;
        check("mid/in_ready", a_in_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid/no_stale", a_out_valid, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
